// File: rtl/l1_icache_refill_ctrl.sv
// Single-MSHR miss sequencer for the L1 I-cache: arbitrates two fetch-port misses,
// requests one line from L2, streams beats into the data array and installs the tag.
module l1_icache_refill_ctrl #(
  parameter int LINE_BYTES  = 64,
  parameter int ASSOC       = 8,
  parameter int INDEX_BITS  = 7,
  parameter int OFFSET_BITS = 6,
  parameter int WAY_W       = $clog2(ASSOC),
  parameter int TAG_BITS    = 64 - OFFSET_BITS - INDEX_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  miss_valid_if1_i,
  input  logic [63:0]           miss_addr_if1_i,
  output logic                  miss_ready_if1_o,
  input  logic                  miss_valid_if2_i,
  input  logic [63:0]           miss_addr_if2_i,
  output logic                  miss_ready_if2_o,
  output logic                  l2_req_valid_o,
  output logic [63:0]           l2_req_addr_o,
  input  logic                  l2_req_ready_i,
  input  logic                  l2_resp_valid_i,
  input  logic [63:0]           l2_resp_data_i,
  input  logic                  l2_resp_last_i,
  output logic                  fill_we_o,
  output logic [INDEX_BITS-1:0] fill_index_o,
  output logic [WAY_W-1:0]      fill_way_o,
  output logic [$clog2(LINE_BYTES/8)-1:0] fill_word_o,
  output logic [63:0]           fill_data_o,
  output logic                  fill_tag_we_o,
  output logic [TAG_BITS-1:0]   fill_tag_o,
  output logic                  refill_done_o,
  output logic [63:0]           refill_addr_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int BEATS  = LINE_BYTES / 8;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LINE_W = 64 - OFFSET_BITS;
  localparam int NSETS  = 1 << INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

  state_t                state_q;
  logic [LINE_W-1:0]     line_q;
  logic [WAY_W-1:0]      way_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  prio_q;  // 0: IF1 wins the next conflict, 1: IF2 wins
  logic                  req_valid_q;
  logic [63:0]           req_addr_q;
  logic                  done_q;
  logic [63:0]           done_addr_q;
  logic                  busy_q;
  logic                  err_q;
  logic [WAY_W-1:0]      rr_q [NSETS];

  logic                  gnt1, gnt2;
  logic                  same_line;
  logic [LINE_W-1:0]     sel_line;
  logic                  fill_fire;

  assign same_line = miss_addr_if1_i[63:OFFSET_BITS] == miss_addr_if2_i[63:OFFSET_BITS];

  always_comb begin
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    if (state_q == S_IDLE) begin
      if (miss_valid_if1_i && miss_valid_if2_i) begin
        if (same_line) begin
          gnt1 = 1'b1;
          gnt2 = 1'b1;
        end else if (prio_q) begin
          gnt2 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt1 = miss_valid_if1_i;
        gnt2 = miss_valid_if2_i;
      end
    end
  end

  assign sel_line  = gnt1 ? miss_addr_if1_i[63:OFFSET_BITS] : miss_addr_if2_i[63:OFFSET_BITS];
  assign fill_fire = (state_q == S_FILL) && l2_resp_valid_i;

  assign miss_ready_if1_o = gnt1;
  assign miss_ready_if2_o = gnt2;

  // Fill port is driven straight from the returning beat; idle value is all-zero.
  assign fill_we_o     = fill_fire;
  assign fill_index_o  = fill_fire ? line_q[INDEX_BITS-1:0] : '0;
  assign fill_way_o    = fill_fire ? way_q : '0;
  assign fill_word_o   = fill_fire ? beat_q : '0;
  assign fill_data_o   = fill_fire ? l2_resp_data_i : '0;
  assign fill_tag_we_o = fill_fire && l2_resp_last_i;
  assign fill_tag_o    = fill_tag_we_o ? line_q[LINE_W-1:INDEX_BITS] : '0;

  assign l2_req_valid_o = req_valid_q;
  assign l2_req_addr_o  = req_addr_q;
  assign refill_done_o  = done_q;
  assign refill_addr_o  = done_addr_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      way_q       <= '0;
      beat_q      <= '0;
      prio_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      done_q      <= 1'b0;
      done_addr_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int s = 0; s < NSETS; s++) rr_q[s] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt1 || gnt2) begin
            state_q     <= S_REQ;
            line_q      <= sel_line;
            way_q       <= rr_q[sel_line[INDEX_BITS-1:0]];
            beat_q      <= '0;
            req_valid_q <= 1'b1;
            req_addr_q  <= {sel_line, {OFFSET_BITS{1'b0}}};
            busy_q      <= 1'b1;
            if (gnt1 ^ gnt2) prio_q <= gnt1;
          end
        end
        S_REQ: begin
          if (l2_req_ready_i) begin
            state_q     <= S_FILL;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
          end
        end
        S_FILL: begin
          if (l2_resp_valid_i) begin
            beat_q <= beat_q + 1'b1;
            if (l2_resp_last_i) begin
              if (beat_q != BEAT_W'(BEATS - 1)) err_q <= 1'b1;
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              done_addr_q <= {line_q, {OFFSET_BITS{1'b0}}};
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          done_addr_q <= '0;
          busy_q      <= 1'b0;
          rr_q[line_q[INDEX_BITS-1:0]] <= rr_q[line_q[INDEX_BITS-1:0]] + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
